soc_glip_dii_framer: RTL and testbench



---
 rtl/soc_glip_dii_framer.sv | 128 ++++++++++++
 tb/tb_soc_glip_dii_framer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/soc_glip_dii_framer.sv
// Host-side DII-to-GLIP framer: buffers one complete debug packet, then emits
// a length header word followed by the packet flits. Oversized packets are dropped.
module soc_glip_dii_framer #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned MAX_PKT_LEN = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow_o
);

    localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_LEN);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_DROP = 2'd1;
    localparam logic [1:0] S_HDR  = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] buf_q [MAX_PKT_LEN];

    logic in_fire;
    logic out_fire;
    logic buf_we;

    assign in_ready   = (state_q == S_FILL) || (state_q == S_DROP);
    assign out_valid  = (state_q == S_HDR)  || (state_q == S_SEND);
    assign overflow_o = ovf_q;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    // The flit that would exceed the buffer is never stored.
    assign buf_we     = (state_q == S_FILL) && in_fire && (cnt_q != MAX_CNT);

    always_comb begin
        out_data = '0;
        case (state_q)
            S_HDR:   out_data = WIDTH'(len_q);
            S_SEND:  out_data = buf_q[rd_ptr_q];
            default: out_data = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = 1'b0;
        case (state_q)
            S_FILL: begin
                if (in_fire) begin
                    if (cnt_q == MAX_CNT) begin
                        cnt_d = '0;
                        if (in_last) begin
                            ovf_d = 1'b1;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (in_last) begin
                        state_d = S_HDR;
                        len_d   = cnt_q + 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (in_fire && in_last) begin
                    state_d = S_FILL;
                    ovf_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_HDR: begin
                if (out_fire) begin
                    state_d  = S_SEND;
                    rd_ptr_d = '0;
                end
            end
            default: begin
                if (out_fire) begin
                    if (rd_ptr_q == len_q - 1'b1) begin
                        state_d = S_FILL;
                        cnt_d   = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FILL;
            cnt_q    <= '0;
            len_q    <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[cnt_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_soc_glip_dii_framer.sv
// Directed bench for soc_glip_dii_framer: framing, stalls, max-length,
// oversized-drop and mid-frame reset.
module tb_soc_glip_dii_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] src_q[$];
    logic [15:0] exp_q[$];
    int cyc;

    soc_glip_dii_framer #(.WIDTH(16), .MAX_PKT_LEN(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Source flits are base+i; expected stream is header then the same flits.
    task automatic load(input int n, input logic [15:0] base);
        src_q = {};
        exp_q = {};
        exp_q.push_back(16'(n));
        for (int i = 0; i < n; i++) begin
            src_q.push_back(base + 16'(i));
            exp_q.push_back(base + 16'(i));
        end
    endtask

    // Called at a negedge; returns at the negedge after the last flit was accepted.
    task automatic send();
        for (int i = 0; i < src_q.size(); i++) begin
            in_valid = 1'b1;
            in_data  = src_q[i];
            in_last  = (i == src_q.size() - 1);
            chk("in_ready_fill", in_ready, 1);
            chk("ovf_quiet", overflow_o, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Receives n words of exp_q; returns at the negedge after the final transfer.
    task automatic recv(input int n, input bit toggle, output int cycles);
        int idx = 0;
        int budget = 0;
        cycles = 0;
        while (idx < n && budget < 200) begin
            out_ready = toggle ? ~out_ready : 1'b1;
            if (out_valid) begin
                chk("out_word", out_data, exp_q[idx]);
                chk("in_ready_busy", in_ready, 0);
                chk("ovf_during_out", overflow_o, 0);
                cycles++;
                if (out_ready) idx++;
            end
            budget++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (idx < n) chk("recv_timeout", idx, n);
    endtask

    task automatic frame_done();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ovf", overflow_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // 3-flit packet, sink always ready
        load(3, 16'hA001);
        send();
        chk("hdr_latency", out_valid, 1);
        recv(4, 1'b0, cyc);
        chk("drain_cycles_3", cyc, 4);
        frame_done();

        // 1-flit packet with a stalling sink
        src_q = {16'h1234};
        exp_q = {16'h0001, 16'h1234};
        send();
        chk("hdr_latency_1", out_valid, 1);
        recv(2, 1'b1, cyc);
        chk("stall_cycles_1", cyc, 3);
        frame_done();

        // Exactly MAX_PKT_LEN flits
        load(12, 16'hC000);
        send();
        chk("hdr_latency_12", out_valid, 1);
        chk("ovf_max_len", overflow_o, 0);
        recv(13, 1'b0, cyc);
        chk("drain_cycles_12", cyc, 13);
        frame_done();

        // 13 flits, last on 13th: immediate discard
        load(13, 16'hD000);
        send();
        chk("ovf13_pulse", overflow_o, 1);
        chk("ovf13_no_out", out_valid, 0);
        @(negedge clk);
        chk("ovf13_pulse_end", overflow_o, 0);
        chk("ovf13_no_out2", out_valid, 0);
        src_q = {16'h5555};
        exp_q = {16'h0001, 16'h5555};
        send();
        chk("after13_hdr", out_valid, 1);
        recv(2, 1'b0, cyc);
        frame_done();

        // 15 flits dropped, then 2-flit packet
        load(15, 16'hE000);
        send();
        chk("ovf15_pulse", overflow_o, 1);
        chk("ovf15_no_out", out_valid, 0);
        @(negedge clk);
        chk("ovf15_pulse_end", overflow_o, 0);
        chk("ovf15_no_out2", out_valid, 0);
        src_q = {16'hBEEF, 16'hCAFE};
        exp_q = {16'h0002, 16'hBEEF, 16'hCAFE};
        send();
        chk("after15_hdr", out_valid, 1);
        recv(3, 1'b0, cyc);
        frame_done();

        // Reset in the middle of sending a 5-flit packet
        load(5, 16'hF000);
        send();
        recv(3, 1'b0, cyc);
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_data", out_data, 0);
        load(2, 16'h7700);
        send();
        chk("post_rst_hdr_lat", out_valid, 1);
        recv(3, 1'b0, cyc);
        frame_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
